// File: rtl/muldiv_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit beside the ALU in execute.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] portA,
  input  logic [WORD_W-1:0] portB,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);
  localparam int W  = WORD_W;
  localparam int CW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE, CALC, FIXUP, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  logic          accept;
  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    msum;
  logic [W:0]    trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]  quo, rem;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    accept = (state_q == IDLE) || (state_q == DONE);
    mag_a  = (op[0] && portA[W-1]) ? -portA : portA;
    mag_b  = (op[0] && portB[W-1]) ? -portB : portB;
    msum   = {1'b0, acc_q[2*W-1:W]}
           + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
    trial  = acc_q[2*W-1:W-1] - {1'b0, b_q};
    prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo    = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem    = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = 1'b0;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIXUP;
        if (is_div_q) begin
          // restoring step: keep the trial remainder only if it did not borrow
          if (trial[W]) acc_d = {acc_q[2*W-2:0], 1'b0};
          else acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {msum, acc_q[W-1:1]};
        end
      end
      FIXUP: begin
        state_d = DONE;
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          is_div_d = op[1];
          sa_d     = op[0] & portA[W-1];
          sb_d     = op[0] & portB[W-1];
          b_d      = mag_b;
          acc_d    = {{W{1'b0}}, mag_a};
          cnt_d    = CW'(W - 1);
          if (op[1] && portB == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CALC) || (state_q == FIXUP);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule
